// File: rtl/fifo_rd_ctrl_if.sv
// Read-side FIFO bundle: write/read pointer exchange, RAM read port and output stream.
// master = the read controller, slave = the surrounding RAM, write domain and consumer.
interface fifo_rd_ctrl_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 16
);
   logic [ADDR_WIDTH:0]   wr_ptr_gray;
   logic [ADDR_WIDTH:0]   rd_ptr_gray;
   logic                  ram_rd_en;
   logic [ADDR_WIDTH-1:0] ram_rd_addr;
   logic [DATA_WIDTH-1:0] ram_rd_data;
   logic [DATA_WIDTH-1:0] dout;
   logic                  dout_valid;
   logic                  dout_ready;
   logic [ADDR_WIDTH:0]   level;
   logic                  empty;
   logic                  ovf_err;

   modport master (
      input  wr_ptr_gray, ram_rd_data, dout_ready,
      output rd_ptr_gray, ram_rd_en, ram_rd_addr, dout, dout_valid, level, empty, ovf_err
   );

   modport slave (
      output wr_ptr_gray, ram_rd_data, dout_ready,
      input  rd_ptr_gray, ram_rd_en, ram_rd_addr, dout, dout_valid, level, empty, ovf_err
   );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Read side of the dual-clock sample FIFO: syncs the Gray write pointer, issues
// 1-cycle-latency RAM reads into a 2-entry output buffer, returns a Gray read pointer.
module fifo_rd_ctrl #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 16
) (
   input  logic           clk,
   input  logic           rst,
   fifo_rd_ctrl_if.master bus
);
   localparam int PW = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

   function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      for (int i = 0; i < PW; i++) b[i] = ^(g >> i);
      return b;
   endfunction

   logic [PW-1:0]         s1, s2, wr_bin, rd_bin, rd_gray, rd_bin_nxt, lvl;
   logic [DATA_WIDTH-1:0] b0, b1;
   logic [1:0]            cnt;
   logic [2:0]            occ;
   logic                  inflight, ovf_err, ovf_now, fire, issue;

   // Difference of two registers, so level only moves on clock edges.
   assign lvl        = wr_bin - rd_bin;
   assign ovf_now    = lvl > DEPTH;
   assign fire       = (cnt != 2'd0) && bus.dout_ready;
   assign occ        = {1'b0, cnt} + {2'b00, inflight} - {2'b00, fire};
   // The live overflow term also blocks the single cycle before ovf_err registers.
   assign issue      = (lvl != '0) && (occ < 3'd2) && !ovf_err && !ovf_now;
   assign rd_bin_nxt = rd_bin + PW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         s1       <= '0;
         s2       <= '0;
         wr_bin   <= '0;
         rd_bin   <= '0;
         rd_gray  <= '0;
         inflight <= 1'b0;
         cnt      <= 2'd0;
         b0       <= '0;
         b1       <= '0;
         ovf_err  <= 1'b0;
      end else begin
         s1       <= bus.wr_ptr_gray;
         s2       <= s1;
         wr_bin   <= g2b(s2);
         ovf_err  <= ovf_err | ovf_now;
         inflight <= issue;
         if (issue) begin
            rd_bin  <= rd_bin_nxt;
            rd_gray <= rd_bin_nxt ^ (rd_bin_nxt >> 1);
         end
         // b0 is always the head; b1 only holds data when two words are buffered.
         case ({inflight, fire})
            2'b10: begin
               if (cnt == 2'd0) b0 <= bus.ram_rd_data;
               else             b1 <= bus.ram_rd_data;
               cnt <= cnt + 2'd1;
            end
            2'b01: begin
               b0  <= b1;
               cnt <= cnt - 2'd1;
            end
            2'b11: begin
               if (cnt == 2'd1) b0 <= bus.ram_rd_data;
               else begin
                  b0 <= b1;
                  b1 <= bus.ram_rd_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.rd_ptr_gray = rd_gray;
   assign bus.ram_rd_en   = issue;
   assign bus.ram_rd_addr = rd_bin[ADDR_WIDTH-1:0];
   assign bus.dout        = b0;
   assign bus.dout_valid  = cnt != 2'd0;
   assign bus.level       = lvl;
   assign bus.empty       = (lvl == '0) && !inflight && (cnt == 2'd0);
   assign bus.ovf_err     = ovf_err;
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: a depth-1024 instance for latency/stream/backpressure/reset
// and a depth-8 instance for the Gray-decode table, wrap-around and overflow.
module tb_fifo_rd_ctrl;
   localparam int AWA = 10;
   localparam int AWB = 3;
   localparam int DW  = 16;

   typedef logic [AWA:0]  pa_t;
   typedef logic [AWB:0]  pb_t;
   typedef logic [DW-1:0] d_t;

   typedef struct {
      pb_t  g;
      pb_t  lvl;
      logic vld;
      logic ovf;
      logic emp;
      pb_t  rdg;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   int   rc_a = 0;
   int   rc_b = 0;
   d_t   q_a[$];
   d_t   q_b[$];

   fifo_rd_ctrl_if #(.ADDR_WIDTH(AWA), .DATA_WIDTH(DW)) bus_a ();
   fifo_rd_ctrl_if #(.ADDR_WIDTH(AWB), .DATA_WIDTH(DW)) bus_b ();

   fifo_rd_ctrl #(.ADDR_WIDTH(AWA), .DATA_WIDTH(DW)) u_a (.clk(clk), .rst(rst), .bus(bus_a.master));
   fifo_rd_ctrl #(.ADDR_WIDTH(AWB), .DATA_WIDTH(DW)) u_b (.clk(clk), .rst(rst), .bus(bus_b.master));

   always #5 clk = ~clk;

   function automatic d_t dat_a(int i);
      return d_t'(i * 37 + 4660);
   endfunction

   function automatic d_t dat_b(int i);
      return d_t'(i * 101 + 3054);
   endfunction

   function automatic int gray(int b);
      return b ^ (b >> 1);
   endfunction

   // 1-cycle-latency RAM models, contents a fixed function of address
   always @(posedge clk) if (bus_a.ram_rd_en) bus_a.ram_rd_data <= dat_a(int'(bus_a.ram_rd_addr));
   always @(posedge clk) if (bus_b.ram_rd_en) bus_b.ram_rd_data <= dat_b(int'(bus_b.ram_rd_addr));

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic mon();
      d_t e;
      if (rst) begin
         rc_a = 0;
         rc_b = 0;
      end else begin
         if (bus_a.ram_rd_en) begin
            chk("addr_a", 32'(bus_a.ram_rd_addr), 32'(rc_a % (1 << AWA)));
            rc_a++;
         end
         if (bus_b.ram_rd_en) begin
            chk("addr_b", 32'(bus_b.ram_rd_addr), 32'(rc_b % (1 << AWB)));
            rc_b++;
         end
         if (bus_a.dout_valid && bus_a.dout_ready) begin
            if (q_a.size() == 0) begin
               checks++; errors++;
               $display("FAIL data_a: got %0h expected nothing at %0t", bus_a.dout, $time);
            end else begin
               e = q_a.pop_front();
               chk("data_a", 32'(bus_a.dout), 32'(e));
            end
         end
         if (bus_b.dout_valid && bus_b.dout_ready) begin
            if (q_b.size() == 0) begin
               checks++; errors++;
               $display("FAIL data_b: got %0h expected nothing at %0t", bus_b.dout, $time);
            end else begin
               e = q_b.pop_front();
               chk("data_b", 32'(bus_b.dout), 32'(e));
            end
         end
         if (u_a.inflight && u_a.cnt == 2'd2 && !(bus_a.dout_valid && bus_a.dout_ready)) begin
            checks++; errors++;
            $display("FAIL buf_full_a: got push into full buffer expected none at %0t", $time);
         end
         if (u_b.inflight && u_b.cnt == 2'd2 && !(bus_b.dout_valid && bus_b.dout_ready)) begin
            checks++; errors++;
            $display("FAIL buf_full_b: got push into full buffer expected none at %0t", $time);
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus_a.wr_ptr_gray = '0;
      bus_b.wr_ptr_gray = '0;
      bus_a.dout_ready  = 1'b0;
      bus_b.dout_ready  = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      q_a.delete();
      q_b.delete();
   endtask

   initial begin
      vec_t vt[8];
      int   n_en, runs_en, runs_v;
      logic pe, pv, seen;

      // gray in, then after settling with dout_ready=0: level, valid, ovf, empty, rd gray
      vt[0] = '{g: 4'd0,  lvl: 4'd0,  vld: 1'b0, ovf: 1'b0, emp: 1'b1, rdg: 4'd0};
      vt[1] = '{g: 4'd1,  lvl: 4'd0,  vld: 1'b1, ovf: 1'b0, emp: 1'b0, rdg: 4'd1};
      vt[2] = '{g: 4'd3,  lvl: 4'd0,  vld: 1'b1, ovf: 1'b0, emp: 1'b0, rdg: 4'd3};
      vt[3] = '{g: 4'd2,  lvl: 4'd1,  vld: 1'b1, ovf: 1'b0, emp: 1'b0, rdg: 4'd3};
      vt[4] = '{g: 4'd7,  lvl: 4'd3,  vld: 1'b1, ovf: 1'b0, emp: 1'b0, rdg: 4'd3};
      vt[5] = '{g: 4'd12, lvl: 4'd6,  vld: 1'b1, ovf: 1'b0, emp: 1'b0, rdg: 4'd3};
      vt[6] = '{g: 4'd13, lvl: 4'd9,  vld: 1'b0, ovf: 1'b1, emp: 1'b0, rdg: 4'd0};
      vt[7] = '{g: 4'd10, lvl: 4'd12, vld: 1'b0, ovf: 1'b1, emp: 1'b0, rdg: 4'd0};

      fork
         forever begin
            @(negedge clk);
            mon();
         end
      join_none

      // reset values, then sync latency with the pointer already at gray 5 (bin 6)
      rst = 1'b1;
      bus_a.wr_ptr_gray = pa_t'(5);
      bus_b.wr_ptr_gray = '0;
      bus_a.dout_ready  = 1'b0;
      bus_b.dout_ready  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", 32'(bus_a.dout_valid), 32'd0);
      chk("rst_rden",  32'(bus_a.ram_rd_en),  32'd0);
      chk("rst_level", 32'(bus_a.level),      32'd0);
      chk("rst_empty", 32'(bus_a.empty),      32'd1);
      chk("rst_ovf",   32'(bus_a.ovf_err),    32'd0);
      chk("rst_rdg",   32'(bus_a.rd_ptr_gray), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("sync_level_c2", 32'(bus_a.level), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("sync_level_c3", 32'(bus_a.level), 32'd6);

      // single word latency
      do_reset();
      bus_a.dout_ready = 1'b1;
      @(posedge clk);
      #1 bus_a.wr_ptr_gray = pa_t'(1);
      q_a.push_back(dat_a(0));
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("one_rden_c2", 32'(bus_a.ram_rd_en), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("one_rden_c3", 32'(bus_a.ram_rd_en), 32'd1);
      chk("one_addr",    32'(bus_a.ram_rd_addr), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("one_valid_c4", 32'(bus_a.dout_valid), 32'd0);
      chk("one_rdg",      32'(bus_a.rd_ptr_gray), 32'd1);
      chk("one_empty_c4", 32'(bus_a.empty), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("one_valid_c5", 32'(bus_a.dout_valid), 32'd1);
      chk("one_dout",     32'(bus_a.dout), 32'(dat_a(0)));
      @(posedge clk);
      @(negedge clk);
      chk("one_empty_c6", 32'(bus_a.empty), 32'd1);

      // streaming 16 words at full rate
      @(posedge clk);
      #1 bus_a.wr_ptr_gray = pa_t'(gray(17));
      for (int i = 1; i < 17; i++) q_a.push_back(dat_a(i));
      n_en = 0; runs_en = 0; runs_v = 0; pe = 1'b0; pv = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus_a.ram_rd_en && !pe) runs_en++;
         if (bus_a.dout_valid && !pv) runs_v++;
         if (bus_a.ram_rd_en) n_en++;
         pe = bus_a.ram_rd_en;
         pv = bus_a.dout_valid;
      end
      chk("stream_reads",      n_en, 16);
      chk("stream_rden_runs",  runs_en, 1);
      chk("stream_valid_runs", runs_v, 1);
      chk("stream_drained",    q_a.size(), 0);

      // backpressure: 8 words, consumer stalled
      @(posedge clk);
      #1 bus_a.dout_ready = 1'b0;
      bus_a.wr_ptr_gray = pa_t'(gray(25));
      for (int i = 17; i < 25; i++) q_a.push_back(dat_a(i));
      n_en = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus_a.ram_rd_en) n_en++;
      end
      chk("bp_reads", n_en, 2);
      chk("bp_level", 32'(bus_a.level), 32'd6);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("bp_hold_valid", 32'(bus_a.dout_valid), 32'd1);
         chk("bp_hold_dout",  32'(bus_a.dout), 32'(dat_a(17)));
      end
      @(posedge clk);
      #1 bus_a.dout_ready = 1'b1;
      repeat (20) @(negedge clk);
      chk("bp_drained", q_a.size(), 0);
      chk("bp_empty",   32'(bus_a.empty), 32'd1);

      // Gray decode / occupancy / overflow table on the depth-8 instance
      for (int i = 0; i < 8; i++) begin
         do_reset();
         bus_b.wr_ptr_gray = vt[i].g;
         repeat (8) @(negedge clk);
         chk($sformatf("tbl%0d_level", i), 32'(bus_b.level),      32'(vt[i].lvl));
         chk($sformatf("tbl%0d_valid", i), 32'(bus_b.dout_valid), 32'(vt[i].vld));
         chk($sformatf("tbl%0d_ovf", i),   32'(bus_b.ovf_err),    32'(vt[i].ovf));
         chk($sformatf("tbl%0d_empty", i), 32'(bus_b.empty),      32'(vt[i].emp));
         chk($sformatf("tbl%0d_rdg", i),   32'(bus_b.rd_ptr_gray), 32'(vt[i].rdg));
      end

      // wrap: 20 words through depth 8; the 4-bit pointer ends at bin 4, gray 6
      do_reset();
      bus_b.dout_ready = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1 bus_b.wr_ptr_gray = pb_t'(gray(k % 16));
         q_b.push_back(dat_b((k - 1) % 8));
      end
      repeat (15) @(negedge clk);
      chk("wrap_reads",   rc_b, 20);
      chk("wrap_rdg",     32'(bus_b.rd_ptr_gray), 32'd6);
      chk("wrap_drained", q_b.size(), 0);
      chk("wrap_empty",   32'(bus_b.empty), 32'd1);
      chk("wrap_ovf",     32'(bus_b.ovf_err), 32'd0);

      // reset while a read is in flight
      do_reset();
      @(posedge clk);
      #1 bus_a.wr_ptr_gray = pa_t'(gray(4));
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         if (bus_a.ram_rd_en) seen = 1'b1;
      end
      chk("mid_issue_seen", 32'(seen), 32'd1);
      @(posedge clk);
      #1 rst = 1'b1;
      bus_a.wr_ptr_gray = '0;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("mid_valid_rst", 32'(bus_a.dout_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("mid_valid_after", 32'(bus_a.dout_valid), 32'd0);
      chk("mid_empty_after", 32'(bus_a.empty), 32'd1);
      chk("mid_level_after", 32'(bus_a.level), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
